// File: rtl/pwm_duty_ramp.sv
// Slews the PWM duty toward a requested target with one inc/dec pulse per interval of rate+2 cycles.
// Optional PWM_DUTY_RAMP_RETARGET_EN: accept a new target while a ramp is running.
module pwm_duty_ramp #(
   parameter int DUTY_W = 3,
   parameter int RATE_W = 8
) (
   input  logic              clk_div,
   input  logic              rst,
   input  logic              en,
   input  logic              tgt_valid,
   input  logic [DUTY_W-1:0] tgt_duty,
   output logic              tgt_ready,
   input  logic [RATE_W-1:0] rate,
   input  logic              sync_valid,
   input  logic [DUTY_W-1:0] sync_duty,
   output logic              duty_inc,
   output logic              duty_dec,
   output logic [DUTY_W-1:0] cur_duty,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, WAIT, STEP} state_t;

   localparam logic [DUTY_W-1:0] HALF = {1'b1, {(DUTY_W-1){1'b0}}};
   localparam logic [DUTY_W-1:0] MAXV = {DUTY_W{1'b1}};

   state_t              state_q, state_d;
   logic [RATE_W-1:0]   cnt_q, cnt_d;
   logic [DUTY_W-1:0]   cur_q, cur_d;
   logic [DUTY_W-1:0]   tgt_q, tgt_d;
   logic                inc_q, inc_d;
   logic                dec_q, dec_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                pend_q, pend_d;
   logic                accept;
   logic [DUTY_W-1:0]   cur_step;
   logic [DUTY_W-1:0]   tgt_nx;

`ifdef PWM_DUTY_RAMP_RETARGET_EN
   assign tgt_ready = en;
`else
   assign tgt_ready = en && (state_q == IDLE);
`endif

   assign accept = tgt_valid && tgt_ready;

   // Shadow follows the pulse the PWM samples at the edge ending STEP, clamped at the rails.
   always_comb begin
      cur_step = cur_q;
      if (inc_q && cur_q != MAXV)
         cur_step = cur_q + 1'b1;
      else if (dec_q && cur_q != '0)
         cur_step = cur_q - 1'b1;
   end

   assign tgt_nx = accept ? tgt_duty : tgt_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cur_d   = cur_q;
      tgt_d   = tgt_q;
      inc_d   = 1'b0;
      dec_d   = 1'b0;
      done_d  = 1'b0;
      pend_d  = 1'b0;
      if (!en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               done_d = pend_q;
               if (accept) begin
                  tgt_d = tgt_duty;
                  if (tgt_duty == cur_q) begin
                     pend_d = 1'b1;
                  end else begin
                     cnt_d   = rate;
                     state_d = WAIT;
                  end
               end
            end
            WAIT: begin
               tgt_d = tgt_nx;
               if (tgt_q == cur_q) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else if (cnt_q == '0) begin
                  state_d = STEP;
                  inc_d   = (tgt_q > cur_q);
                  dec_d   = (tgt_q < cur_q);
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            STEP: begin
               cur_d = cur_step;
               tgt_d = tgt_nx;
               if (cur_step == tgt_nx) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  cnt_d   = rate;
                  state_d = WAIT;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      // A direct duty write wins over everything, matching the PWM's own load priority.
      if (sync_valid) begin
         cur_d   = sync_duty;
         tgt_d   = sync_duty;
         state_d = IDLE;
         inc_d   = 1'b0;
         dec_d   = 1'b0;
         done_d  = 1'b0;
         pend_d  = 1'b0;
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_div or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         cur_q   <= HALF;
         tgt_q   <= HALF;
         inc_q   <= 1'b0;
         dec_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cur_q   <= cur_d;
         tgt_q   <= tgt_d;
         inc_q   <= inc_d;
         dec_q   <= dec_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pend_q  <= pend_d;
      end
   end

   assign duty_inc = inc_q;
   assign duty_dec = dec_q;
   assign cur_duty = cur_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp; edges are counted from the acceptance edge.
module tb_pwm_duty_ramp;

   logic       clk_div = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b1;
   logic       tgt_valid = 1'b0;
   logic [2:0] tgt_duty = '0;
   logic       tgt_ready;
   logic [7:0] rate = '0;
   logic       sync_valid = 1'b0;
   logic [2:0] sync_duty = '0;
   logic       duty_inc, duty_dec, busy, done;
   logic [2:0] cur_duty;

   int checks = 0;
   int errors = 0;
   int n_inc, n_dec, first_p, last_p, done_edge, done_cnt, both_cnt;
   bit busy_seen;

   pwm_duty_ramp #(.DUTY_W(3), .RATE_W(8)) dut (
      .clk_div(clk_div), .rst(rst), .en(en),
      .tgt_valid(tgt_valid), .tgt_duty(tgt_duty), .tgt_ready(tgt_ready),
      .rate(rate), .sync_valid(sync_valid), .sync_duty(sync_duty),
      .duty_inc(duty_inc), .duty_dec(duty_dec), .cur_duty(cur_duty),
      .busy(busy), .done(done)
   );

   always #5 clk_div = ~clk_div;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_div);
      #1;
   endtask

   task automatic offer(input logic [2:0] t);
      tgt_valid = 1'b1;
      tgt_duty  = t;
      tick();
      tgt_valid = 1'b0;
   endtask

   task automatic sync_to(input logic [2:0] v);
      sync_valid = 1'b1;
      sync_duty  = v;
      tick();
      sync_valid = 1'b0;
   endtask

   task automatic run(input int max_edges, input bit stop_on_done);
      bit stop;
      n_inc = 0; n_dec = 0; first_p = -1; last_p = -1;
      done_edge = -1; done_cnt = 0; both_cnt = 0; busy_seen = 0;
      stop = 0;
      for (int k = 1; k <= max_edges && !stop; k++) begin
         tick();
         if (duty_inc) n_inc++;
         if (duty_dec) n_dec++;
         if (duty_inc && duty_dec) both_cnt++;
         if (duty_inc || duty_dec) begin
            if (first_p < 0) first_p = k;
            last_p = k;
         end
         if (busy) busy_seen = 1;
         if (done) begin
            done_cnt++;
            done_edge = k;
            if (stop_on_done) stop = 1;
         end
      end
   endtask

   initial begin
      #12 rst = 1'b0;
      #1;
      chk("rst_cur", cur_duty, 4);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pulses", {duty_inc, duty_dec}, 0);
      chk("rst_ready", tgt_ready, 1);

      // Ramp up 4 -> 7, rate 2
      rate = 8'd2;
      tick();
      offer(3'd7);
      chk("up_busy", busy, 1);
      run(40, 1);
      chk("up_ninc", n_inc, 3);
      chk("up_ndec", n_dec, 0);
      chk("up_first", first_p, 3);
      chk("up_last", last_p, 11);
      chk("up_done_edge", done_edge, 12);
      chk("up_cur", cur_duty, 7);
      tick();
      chk("up_done_once", done, 0);

      // Ramp down 4 -> 0, rate 0
      sync_to(3'd4);
      rate = 8'd0;
      offer(3'd0);
      run(40, 1);
      chk("dn_ndec", n_dec, 4);
      chk("dn_ninc", n_inc, 0);
      chk("dn_first", first_p, 1);
      chk("dn_last", last_p, 7);
      chk("dn_done_edge", done_edge, 8);
      chk("dn_cur", cur_duty, 0);
      chk("dn_busy", busy, 0);
      chk("dn_both", both_cnt, 0);

      // Equal target
      sync_to(3'd4);
      chk("sync_cur", cur_duty, 4);
      offer(3'd4);
      chk("eq_done_e0", done, 0);
      run(5, 1);
      chk("eq_done_edge", done_edge, 1);
      chk("eq_pulses", n_inc + n_dec, 0);
      chk("eq_busy", busy_seen, 0);
      tick();
      chk("eq_done_once", done, 0);

      // Sync mid-ramp
      rate = 8'd2;
      offer(3'd7);
      run(4, 0);
      chk("sy_cur_mid", cur_duty, 5);
      sync_valid = 1'b1;
      sync_duty  = 3'd2;
      tick();
      sync_valid = 1'b0;
      chk("sy_cur", cur_duty, 2);
      chk("sy_busy", busy, 0);
      chk("sy_done", done, 0);
      chk("sy_ready", tgt_ready, 1);
      run(10, 0);
      chk("sy_quiet", n_inc + n_dec + done_cnt, 0);
      offer(3'd3);
      run(20, 1);
      chk("sy_ninc", n_inc, 1);
      chk("sy_done_edge", done_edge, 4);
      chk("sy_cur_end", cur_duty, 3);

      // Enable drop during WAIT
      sync_to(3'd4);
      offer(3'd7);
      tick();
      en = 1'b0;
      #1;
      chk("en_ready_lo", tgt_ready, 0);
      tick();
      chk("en_busy", busy, 0);
      run(10, 0);
      chk("en_quiet", n_inc + n_dec, 0);
      chk("en_cur", cur_duty, 4);
      en = 1'b1;
      #1;
      chk("en_ready_hi", tgt_ready, 1);
      run(10, 0);
      chk("en_resume", n_inc + n_dec + done_cnt, 0);
      chk("en_busy2", busy_seen, 0);

      // Second offer during WAIT, rate 3
      rate = 8'd3;
      offer(3'd7);
      tgt_valid = 1'b1;
      tgt_duty  = 3'd5;
      #1;
`ifdef PWM_DUTY_RAMP_RETARGET_EN
      chk("rt_ready", tgt_ready, 1);
      tick();
      tgt_valid = 1'b0;
      run(40, 1);
      chk("rt_ninc", n_inc, 1);
      chk("rt_first", first_p, 3);
      chk("rt_done_edge", done_edge, 4);
      chk("rt_cur", cur_duty, 5);
`else
      chk("rt_ready", tgt_ready, 0);
      tick();
      tgt_valid = 1'b0;
      run(40, 1);
      chk("rt_ninc", n_inc, 3);
      chk("rt_first", first_p, 3);
      chk("rt_done_edge", done_edge, 14);
      chk("rt_cur", cur_duty, 7);
      chk("rt_ready_after", tgt_ready, 1);
`endif

      // Asynchronous reset mid-ramp
      rate = 8'd2;
      offer(3'd0);
      run(4, 0);
      rst = 1'b1;
      #1;
      chk("ar_cur", cur_duty, 4);
      chk("ar_busy", busy, 0);
      chk("ar_pulses", {duty_inc, duty_dec}, 0);
      #3 rst = 1'b0;
      tick();
      chk("ar_ready", tgt_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwm_duty_ramp.md
# pwm_duty_ramp

Slew-rate controller upstream of the PWM generator. Accepts a target duty word over a valid/ready handshake and walks the PWM duty toward it with single-cycle `duty_inc`/`duty_dec` pulses, one pulse per programmable interval. It keeps a shadow copy of the PWM's working duty, so no large duty jumps reach the output stage. It runs on the same divided clock `clk_div` as the PWM.

## Interface
- `DUTY_W`, default 3: duty word width. Must match the PWM duty width.
- `RATE_W`, default 8: width of the step-interval input.
- `clk_div`, in, 1: divided clock, shared with the PWM; all logic is on its rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `en`, in, 1: block enable; the same signal as the PWM `en`.
- `tgt_valid`, in, 1: a target duty is offered.
- `tgt_duty`, in, DUTY_W: target duty value.
- `tgt_ready`, out, 1: the block can accept a target.
- `rate`, in, RATE_W: spacing between steps. Sampled when a target is accepted and at each step.
- `sync_valid`, in, 1: the PWM duty bus was written directly; overwrite the shadow.
- `sync_duty`, in, DUTY_W: the value written to the PWM duty bus.
- `duty_inc`, out, 1: step-up pulse to the PWM.
- `duty_dec`, out, 1: step-down pulse to the PWM.
- `cur_duty`, out, DUTY_W: shadow of the PWM working duty.
- `busy`, out, 1: a ramp is in progress.
- `done`, out, 1: one-cycle pulse when the target is reached.

## Operation
- States:
  - IDLE: waiting for a target.
  - WAIT: interval counter running.
  - STEP: one pulse cycle.
- Reset values:
  - state IDLE.
  - `cur_duty` = 3'b100 (half scale), matching the PWM reset duty.
  - `duty_inc`, `duty_dec`, `busy`, `done` all 0.
  - target register 3'b100.
  - counter 0.
- `tgt_ready` = `en` && (state == IDLE). It is combinational; with macro behaviour see Configuration.
- IDLE, on `tgt_valid && tgt_ready`:
  - Latch `tgt_duty`.
  - If `tgt_duty == cur_duty`: stay in IDLE and pulse `done` in the next cycle.
  - Otherwise: load the counter with `rate`, go to WAIT, set `busy`.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter == 0, go to STEP.
- STEP (exactly one cycle):
  - Assert `duty_inc` if target > `cur_duty`, else assert `duty_dec`. Never both.
  - At the edge that ends the STEP cycle (the edge where the PWM samples the pulse), `cur_duty` moves ±1.
  - If the new `cur_duty` == target: go to IDLE, clear `busy`, pulse `done` for one cycle.
  - Otherwise: reload the counter with `rate` and go to WAIT.
- Arithmetic:
  - `cur_duty` saturates at 0 and 2^DUTY_W−1; it never wraps.
  - Any in-range target is reachable, so saturation is only a safety net.
  - The counter is unsigned RATE_W bits.
- `sync_valid` has the highest priority after reset. On the next edge:
  - `cur_duty` = `sync_duty` and target = `sync_duty`.
  - State goes to IDLE; `busy` is cleared.
  - No pulse and no `done` are produced.
- `en` low:
  - State is forced to IDLE; pulses and `busy` are forced to 0.
  - `cur_duty` and target are held. The PWM ignores steps while disabled, so the shadow stays valid.
  - An aborted ramp does not resume; a new target is required.
- Simultaneous events:
  - `sync_valid` beats `tgt_valid`, and `sync_valid` beats a STEP in the same cycle.
  - When `sync_valid` and STEP coincide, the STEP pulse is still driven that cycle, and the shadow takes `sync_duty`. This matches the PWM, where the duty load beats inc/dec.
- Reset mid-ramp: everything returns to its reset value immediately (asynchronous).

## Timing
- Target accepted at edge E0 → first pulse is high from edge E0+rate+1 to edge E0+rate+2.
- Successive pulses are spaced rate+2 cycles apart, rising edge to rising edge.
- A ramp of N steps takes N·(rate+2) cycles, from acceptance to the `done` rising edge.
- `done` rises at the same edge that ends the final pulse, i.e. when `cur_duty` reaches the target.
- For an equal target, `done` rises at edge E0+1.
- `duty_inc`, `duty_dec`, `busy`, `done` and `cur_duty` are all registered.

## Configuration
- Macro: `PWM_DUTY_RAMP_RETARGET_EN`.
- When defined:
  - `tgt_ready` = `en` in every state.
  - A target accepted during WAIT or STEP replaces the latched target; the counter is not reloaded.
  - Direction is re-evaluated at the next STEP.
  - If the new target equals `cur_duty` after a STEP, the block finishes with a `done` pulse.
  - If the new target equals `cur_duty` during WAIT, the block goes to IDLE at the next edge with `done`.
- When undefined: `tgt_ready` is low while `busy` and new targets are held off.

## Test plan
- After reset, `en`=1, `rate`=2, target 7 → exactly 3 `duty_inc` pulses, 4 cycles apart. The first pulse rises 3 edges after acceptance. `cur_duty` goes 4→7, then `done` pulses once; `duty_dec` is never asserted.
- `rate`=0, target 0 from 4 → 4 `duty_dec` pulses, 2 cycles apart; `cur_duty` = 0; `busy` is low after the last pulse.
- Target 4 while `cur_duty`=4 → no pulses; `done` is high at edge E0+1 only; `busy` stays 0.
- Mid-ramp (target 7, `cur_duty`=5) assert `sync_valid` with `sync_duty`=2 → next edge `cur_duty`=2, state IDLE, no `done`. A later target 3 gives 1 `duty_inc`.
- Drop `en` during WAIT of a 4→7 ramp → pulses stop, `cur_duty` is held at its value, `tgt_ready` = 0. Re-enable → IDLE with `tgt_ready` = 1 and no spontaneous pulses.
- With the macro, target 7 then target 5 during the first WAIT (`rate`=3) → exactly 1 `duty_inc`, then `done`, ending at `cur_duty`=5. Without the macro, the second offer sees `tgt_ready`=0 until `done`.
